// File: rtl/data_memory_sized_pkg.sv
// data_memory_sized_pkg: access-size encodings and FSM state constants shared with the control unit
package data_memory_sized_pkg;
    localparam logic [1:0] SIZE_BYTE    = 2'b00;
    localparam logic [1:0] SIZE_HALF    = 2'b01;
    localparam logic [1:0] SIZE_WORD    = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/data_memory_sized_if.sv
// data_memory_sized_if: request/response bus between the requester (master) and the data memory (slave)
// Signals: address, write_data, mem_read, mem_write, mem_size, mem_unsigned (master -> slave);
//          read_data, ready, misaligned (slave -> master)
interface data_memory_sized_if;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] read_data;
    logic        ready;
    logic        misaligned;
    modport master (output address, write_data, mem_read, mem_write, mem_size, mem_unsigned,
                    input read_data, ready, misaligned);
    modport slave (input address, write_data, mem_read, mem_write, mem_size, mem_unsigned,
                   output read_data, ready, misaligned);
endinterface

// File: rtl/data_memory_sized_mem_lane_align.sv
// mem_lane_align: combinational lane steering for byte/half/word stores and sign/zero-extended loads
// Ports: i_size, i_offset (address[1:0]), i_unsigned, i_old_word, i_store_data in;
//        o_store_word (old word with addressed lanes replaced), o_byte_en, o_load_data, o_misaligned out
module mem_lane_align
    import data_memory_sized_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_offset,
    input  logic        i_unsigned,
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_store_word,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);
    logic [31:0] w_lanes;
    logic [31:0] w_shifted;
    always_comb begin
        o_misaligned = i_size == SIZE_ILLEGAL || (i_size == SIZE_HALF && i_offset[0]) ||
                       (i_size == SIZE_WORD && i_offset != 2'd0);
        o_byte_en = o_misaligned ? 4'b0000 :
                    i_size == SIZE_BYTE ? 4'b0001 << i_offset :
                    i_size == SIZE_HALF ? (i_offset[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        // Replicate the low store bits into every lane so the byte enables alone pick the target
        w_lanes = i_size == SIZE_BYTE ? {4{i_store_data[7:0]}} :
                  i_size == SIZE_HALF ? {2{i_store_data[15:0]}} : i_store_data;
        o_store_word = i_old_word;
        for (int l = 0; l < 4; l++)
            if (o_byte_en[l]) o_store_word[8*l +: 8] = w_lanes[8*l +: 8];
        w_shifted = i_old_word >> {i_offset, 3'b000};
        o_load_data = o_misaligned ? 32'd0 :
                      i_size == SIZE_BYTE ? {{24{~i_unsigned & w_shifted[7]}}, w_shifted[7:0]} :
                      i_size == SIZE_HALF ? {{16{~i_unsigned & w_shifted[15]}}, w_shifted[15:0]} : i_old_word;
    end
endmodule

// File: rtl/data_memory_sized.sv
// data_memory_sized: byte-addressed data memory with LB/LH/LW/SB/SH/SW, wait states and ready handshake
// Ports: clk; reset (async, active-high); bus (slave modport): address, write_data, mem_read, mem_write,
//        mem_size, mem_unsigned in; read_data, ready (one-cycle pulse), misaligned (valid with ready) out
module data_memory_sized
    import data_memory_sized_pkg::*;
#(
    parameter int    DATA_WIDTH  = 32,
    parameter int    DEPTH_WORDS = 256,
    parameter int    WAIT_STATES = 0,
    parameter string INIT_FILE   = ""
) (
    input logic                clk,
    input logic                reset,
    data_memory_sized_if.slave bus
);
    localparam int AW = $clog2(DEPTH_WORDS);
    if (DATA_WIDTH != 32 || DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0 ||
        WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_params
        $error("data_memory_sized: unsupported parameter set");
    end
    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic [AW-1:0] r_idx;
    logic [1:0]    r_off;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic          r_write;
    logic [31:0]   r_wdata;
    logic [31:0]   r_read_data;
    logic          r_mis;
    logic          w_idle;
    logic          w_go;
    logic          w_enter_done;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_off;
    logic [1:0]    w_size;
    logic          w_unsigned;
    logic [31:0]   w_wdata;
    logic [31:0]   w_store_word;
    logic [31:0]   w_load;
    logic [3:0]    w_be;
    logic          w_mis;
    logic          w_unused;
    // In IDLE the aligner sees the live bus so a zero-wait access can capture its result at the accept edge;
    // afterwards it works from the latched request.
    assign w_idle       = r_state == ST_IDLE;
    assign w_go         = bus.mem_read | bus.mem_write;
    assign w_idx        = w_idle ? bus.address[AW+1:2] : r_idx;
    assign w_off        = w_idle ? bus.address[1:0] : r_off;
    assign w_size       = w_idle ? bus.mem_size : r_size;
    assign w_unsigned   = w_idle ? bus.mem_unsigned : r_unsigned;
    assign w_wdata      = w_idle ? bus.write_data : r_wdata;
    assign w_enter_done = (w_idle && w_go && WAIT_STATES == 0) || (r_state == ST_WAIT && r_cnt == 4'd0);
    assign w_unused     = ^bus.address[31:AW+2];
    mem_lane_align u_align (
        .i_size       (w_size),
        .i_offset     (w_off),
        .i_unsigned   (w_unsigned),
        .i_old_word   (r_mem[w_idx]),
        .i_store_data (w_wdata),
        .o_store_word (w_store_word),
        .o_byte_en    (w_be),
        .o_load_data  (w_load),
        .o_misaligned (w_mis)
    );
    assign bus.read_data  = r_read_data;
    assign bus.ready      = r_state == ST_DONE;
    assign bus.misaligned = r_mis;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_idx       <= '0;
            r_off       <= 2'd0;
            r_size      <= SIZE_BYTE;
            r_unsigned  <= 1'b0;
            r_write     <= 1'b0;
            r_wdata     <= 32'd0;
            r_read_data <= 32'd0;
            r_mis       <= 1'b0;
        end else begin
            // Load result is taken before the store commits, so read+write returns the pre-store word
            if (w_enter_done) r_read_data <= w_load;
            r_mis <= w_enter_done & w_mis;
            case (r_state)
                ST_IDLE: if (w_go) begin
                    r_idx      <= bus.address[AW+1:2];
                    r_off      <= bus.address[1:0];
                    r_size     <= bus.mem_size;
                    r_unsigned <= bus.mem_unsigned;
                    r_write    <= bus.mem_write;
                    r_wdata    <= bus.write_data;
                    r_cnt      <= 4'(WAIT_STATES);
                    r_state    <= WAIT_STATES == 0 ? ST_DONE : ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd0) r_state <= ST_DONE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end
    // Stores commit on the edge leaving DONE; misaligned accesses have no lanes enabled
    always_ff @(posedge clk) begin
        for (int l = 0; l < 4; l++)
            if (r_state == ST_DONE && r_write && w_be[l]) r_mem[r_idx][8*l +: 8] <= w_store_word[8*l +: 8];
    end
endmodule

// File: tb/tb_data_memory_sized.sv
// tb_data_memory_sized: directed and randomized checks of data_memory_sized against a word-array model
module tb_data_memory_sized;
    logic clk = 1'b0;
    logic rst0;
    logic rst3;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [31:0] mdl [2][256];
    always #5 clk = ~clk;
    data_memory_sized_if bus0 ();
    data_memory_sized_if bus3 ();
    data_memory_sized #(.WAIT_STATES(0)) dut0 (.clk(clk), .reset(rst0), .bus(bus0.slave));
    data_memory_sized #(.WAIT_STATES(3)) dut3 (.clk(clk), .reset(rst3), .bus(bus3.slave));

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic int nbytes(int sz);
        return sz == 0 ? 1 : sz == 1 ? 2 : 4;
    endfunction

    function automatic bit ref_mis(int sz, int off);
        return sz == 3 || (off % nbytes(sz)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(logic [31:0] w, int sz, int off, bit uns);
        int n = nbytes(sz);
        longint v = (longint'(w) >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
        if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    task automatic drive(int inst, bit rd, bit wr, int sz, bit uns, logic [31:0] addr, logic [31:0] data);
        if (inst == 0) begin
            bus0.mem_read = rd; bus0.mem_write = wr; bus0.mem_size = 2'(sz);
            bus0.mem_unsigned = uns; bus0.address = addr; bus0.write_data = data;
        end else begin
            bus3.mem_read = rd; bus3.mem_write = wr; bus3.mem_size = 2'(sz);
            bus3.mem_unsigned = uns; bus3.address = addr; bus3.write_data = data;
        end
    endtask

    task automatic access(string tag, int inst, bit rd, bit wr, int sz, bit uns,
                          logic [31:0] addr, logic [31:0] data);
        int lat = inst == 0 ? 0 : 4;
        int k = inst == 0 ? 0 : 1;
        int idx = int'(addr[9:2]);
        int off = int'(addr[1:0]);
        bit mis = ref_mis(sz, off);
        logic [31:0] exp_rd = mis ? 32'd0 : ref_load(mdl[k][idx], sz, off, uns);
        @(negedge clk);
        drive(inst, rd, wr, sz, uns, addr, data);
        @(posedge clk);
        #1;
        for (int n = 0; n <= lat; n++) begin
            if (n > 0) begin
                @(posedge clk);
                #1;
            end
            check($sformatf("%s ready@%0d", tag, n), 32'(inst == 0 ? bus0.ready : bus3.ready), 32'(n == lat));
        end
        drive(inst, 1'b0, 1'b0, 0, 1'b0, 32'd0, 32'd0);
        check({tag, " misaligned"}, 32'(inst == 0 ? bus0.misaligned : bus3.misaligned), 32'(mis));
        if (rd || mis) check({tag, " read_data"}, inst == 0 ? bus0.read_data : bus3.read_data, exp_rd);
        if (wr && !mis)
            for (int b = 0; b < nbytes(sz); b++) mdl[k][idx][8*(off+b) +: 8] = data[8*b +: 8];
        @(posedge clk);
        #1;
        check({tag, " ready clears"}, 32'(inst == 0 ? bus0.ready : bus3.ready), 32'd0);
        check({tag, " misaligned clears"}, 32'(inst == 0 ? bus0.misaligned : bus3.misaligned), 32'd0);
    endtask

    initial begin
        rst0 = 1'b1;
        rst3 = 1'b1;
        drive(0, 1'b0, 1'b0, 0, 1'b0, 32'd0, 32'd0);
        drive(3, 1'b0, 1'b0, 0, 1'b0, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("reset read_data0", bus0.read_data, 32'd0);
        check("reset ready0", 32'(bus0.ready), 32'd0);
        check("reset misaligned0", 32'(bus0.misaligned), 32'd0);
        check("reset read_data3", bus3.read_data, 32'd0);
        check("reset ready3", 32'(bus3.ready), 32'd0);
        check("reset misaligned3", 32'(bus3.misaligned), 32'd0);
        @(negedge clk);
        rst0 = 1'b0;
        rst3 = 1'b0;
        for (int i = 0; i < 16; i++) access("fill", 0, 1'b0, 1'b1, 2, 1'b0, 32'(i * 4), $urandom);
        access("SW 4", 0, 1'b0, 1'b1, 2, 1'b0, 32'h4, 32'h12345678);
        access("LW 4", 0, 1'b1, 1'b0, 2, 1'b0, 32'h4, 32'h0);
        check("LW 4 literal", bus0.read_data, 32'h12345678);
        access("SB 5", 0, 1'b0, 1'b1, 0, 1'b0, 32'h5, 32'h000000AB);
        access("LW 4 after SB", 0, 1'b1, 1'b0, 2, 1'b0, 32'h4, 32'h0);
        check("LW 4 after SB literal", bus0.read_data, 32'h1234AB78);
        access("LB 5", 0, 1'b1, 1'b0, 0, 1'b0, 32'h5, 32'h0);
        check("LB 5 literal", bus0.read_data, 32'hFFFFFFAB);
        access("LBU 5", 0, 1'b1, 1'b0, 0, 1'b1, 32'h5, 32'h0);
        check("LBU 5 literal", bus0.read_data, 32'h000000AB);
        access("SH 6", 0, 1'b0, 1'b1, 1, 1'b0, 32'h6, 32'h00008001);
        access("LH 6", 0, 1'b1, 1'b0, 1, 1'b0, 32'h6, 32'h0);
        check("LH 6 literal", bus0.read_data, 32'hFFFF8001);
        access("LHU 6", 0, 1'b1, 1'b0, 1, 1'b1, 32'h6, 32'h0);
        check("LHU 6 literal", bus0.read_data, 32'h00008001);
        access("LW 6 mis", 0, 1'b1, 1'b0, 2, 1'b0, 32'h6, 32'h0);
        access("SH 7 mis", 0, 1'b0, 1'b1, 1, 1'b0, 32'h7, 32'hFFFFFFFF);
        access("size 11 mis", 0, 1'b1, 1'b1, 3, 1'b0, 32'h4, 32'hFFFFFFFF);
        access("LW 4 after mis", 0, 1'b1, 1'b0, 2, 1'b0, 32'h4, 32'h0);
        check("LW 4 after mis literal", bus0.read_data, 32'h8001AB78);
        access("RW 4 pre-store", 0, 1'b1, 1'b1, 2, 1'b0, 32'h4, 32'h0BADF00D);
        check("RW 4 pre-store literal", bus0.read_data, 32'h8001AB78);
        access("SW 400 wrap", 0, 1'b0, 1'b1, 2, 1'b0, 32'h400, 32'hCAFEF00D);
        access("LW 0 wrap", 0, 1'b1, 1'b0, 2, 1'b0, 32'h0, 32'h0);
        check("LW 0 wrap literal", bus0.read_data, 32'hCAFEF00D);
        for (int i = 0; i < 60; i++) begin
            int op = $urandom_range(0, 2);
            logic [31:0] a = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(0, 63));
            access($sformatf("rand%0d", i), 0, op != 1, op != 0, $urandom_range(0, 3),
                   1'($urandom_range(0, 1)), a, $urandom);
        end
        access("W3 SW 8", 3, 1'b0, 1'b1, 2, 1'b0, 32'h8, 32'h11112222);
        access("W3 LW 8", 3, 1'b1, 1'b0, 2, 1'b0, 32'h8, 32'h0);
        check("W3 LW 8 literal", bus3.read_data, 32'h11112222);
        @(negedge clk);
        drive(3, 1'b0, 1'b1, 2, 1'b0, 32'h8, 32'hDEADBEEF);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        drive(3, 1'b0, 1'b0, 0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        rst3 = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(posedge clk);
            #1;
            check($sformatf("abort no ready@%0d", n), 32'(bus3.ready), 32'd0);
        end
        access("W3 LW 8 after abort", 3, 1'b1, 1'b0, 2, 1'b0, 32'h8, 32'h0);
        check("W3 abort literal", bus3.read_data, 32'h11112222);
        access("W3 LB 9", 3, 1'b1, 1'b0, 0, 1'b0, 32'h9, 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
